// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: phase encoding, command codes,
// packed state field offsets and small position helpers.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } phase_t;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_START = 3'd5;

    localparam int STATE_PHASE_LSB = 0;
    localparam int STATE_HP_LSB    = 2;
    localparam int STATE_PAD_LSB   = 10;
    localparam int STATE_SCORE_LSB = 16;

    function automatic logic [15:0] packPos(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

    function automatic logic [7:0] unpackX(input logic [15:0] pos);
        return pos[7:0];
    endfunction

    function automatic logic [7:0] unpackY(input logic [15:0] pos);
        return pos[15:8];
    endfunction

    // One step towards a bound, computed one bit wider so it can never wrap.
    function automatic logic [7:0] stepClamp(input logic [7:0] p, input logic increase,
                                             input logic [7:0] lo, input logic [7:0] hi,
                                             input logic [7:0] step);
        logic [8:0] wide;
        if (increase) begin
            wide = {1'b0, p} + {1'b0, step};
            if (wide > {1'b0, hi}) begin
                wide = {1'b0, hi};
            end
        end else begin
            if ({1'b0, p} < ({1'b0, lo} + {1'b0, step})) begin
                wide = {1'b0, lo};
            end else begin
                wide = {1'b0, p} - {1'b0, step};
            end
        end
        return wide[7:0];
    endfunction

    function automatic logic [7:0] absDiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Bullet colours cycle through 1..7, never 0.
    function automatic logic [2:0] nextColor(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : (c + 3'd1);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registers the active-low vsync and emits a one-cycle pulse on its falling edge.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsyncQ;
    logic vsyncQd;

    // Two-stage sample of vsync; idle level is high so reset does not fake an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsyncQ  <= 1'b1;
            vsyncQd <= 1'b1;
        end else begin
            vsyncQ  <= vsync;
            vsyncQd <= vsyncQ;
        end
    end

    assign tick = vsyncQd & ~vsyncQ;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game controller: phase sequencing, player/bullet motion,
// collision, HP and score, all updated once per frame in vertical blanking.
// Optional macro GAME_LFSR_SPAWN_EN picks bullet respawn rows from an LFSR
// instead of aiming at the player.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [7:0] X_MIN      = 8'd16,
    parameter logic [7:0] X_MAX      = 8'd144,
    parameter logic [7:0] Y_MIN      = 8'd16,
    parameter logic [7:0] Y_MAX      = 8'd112,
    parameter logic [7:0] STEP       = 8'd4,
    parameter logic [7:0] SPEED      = 8'd4,
    parameter logic [7:0] HP_INIT    = 8'd5,
    parameter logic [7:0] HIT_FRAMES = 8'd16,
    parameter logic [7:0] BOX        = 8'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    output logic [15:0] player_pos,
    output logic [15:0] bullet_pos,
    output logic [2:0]  bullet_color,
    output logic [31:0] state,
    output logic        is_render
);

    localparam logic [7:0] X_CENTRE     = 8'((9'(X_MIN) + 9'(X_MAX)) >> 1);
    localparam logic [7:0] Y_CENTRE     = 8'((9'(Y_MIN) + 9'(Y_MAX)) >> 1);
    localparam logic [8:0] RESPAWN_EDGE = 9'(X_MIN) + 9'(SPEED);

    phase_t      phase, phaseNext;
    logic [7:0]  hp, hpNext;
    logic [15:0] score, scoreNext;
    logic [7:0]  posX, posXNext, posY, posYNext;
    logic [7:0]  bulletX, bulletXNext, bulletY, bulletYNext;
    logic [2:0]  color, colorNext;
    logic [7:0]  hitCnt, hitCntNext;
    logic [2:0]  pending, pendingNext;
    logic        isRenderNext;
    logic        tick;
    logic        updateEn;

    logic [7:0]  pxMoved, pyMoved, bxMoved, byMoved, spawnY, hpDec;
    logic        respawn, collide;

    frame_tick_gen uTick (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .tick  (tick)
    );

    // Delay the tick by one cycle so the frame update lands two clocks after vsync falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            updateEn <= 1'b0;
        end else begin
            updateEn <= tick;
        end
    end

`ifdef GAME_LFSR_SPAWN_EN
    localparam logic [7:0] Y_SPAN = 8'(9'(Y_MAX) - 9'(Y_MIN) + 9'd1);
    logic [7:0] lfsr;

    // Spawn-row LFSR (x^8+x^6+x^5+x^4+1) stepping once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (updateEn) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign spawnY = Y_MIN + (lfsr % Y_SPAN);
`else
    assign spawnY = posY;
`endif

    // Candidate positions for this frame: player move, bullet advance or respawn, hit test.
    always_comb begin
        pxMoved = posX;
        pyMoved = posY;
        case (pending)
            CMD_UP:    pyMoved = stepClamp(posY, 1'b0, Y_MIN, Y_MAX, STEP);
            CMD_DOWN:  pyMoved = stepClamp(posY, 1'b1, Y_MIN, Y_MAX, STEP);
            CMD_LEFT:  pxMoved = stepClamp(posX, 1'b0, X_MIN, X_MAX, STEP);
            CMD_RIGHT: pxMoved = stepClamp(posX, 1'b1, X_MIN, X_MAX, STEP);
            default:   ;
        endcase
        respawn = (9'(bulletX) < RESPAWN_EDGE);
        bxMoved = respawn ? X_MAX : (bulletX - SPEED);
        byMoved = respawn ? spawnY : bulletY;
        collide = (phase == PLAY) && (absDiff(pxMoved, bxMoved) < BOX)
                  && (absDiff(pyMoved, byMoved) < BOX);
        hpDec   = (hp == 8'd0) ? 8'd0 : (hp - 8'd1);
    end

    // Next-state logic: command latch every cycle, game rules only on the update cycle.
    always_comb begin
        phaseNext   = phase;
        hpNext      = hp;
        scoreNext   = score;
        posXNext    = posX;
        posYNext    = posY;
        bulletXNext = bulletX;
        bulletYNext = bulletY;
        colorNext   = color;
        hitCntNext  = hitCnt;
        pendingNext = pending;

        if (cmd_valid && (cmd != CMD_NONE)) begin
            pendingNext = cmd;
        end else if (updateEn) begin
            pendingNext = CMD_NONE;
        end

        if (updateEn) begin
            case (phase)
                IDLE: begin
                    if (pending == CMD_START) begin
                        phaseNext   = PLAY;
                        hpNext      = HP_INIT;
                        scoreNext   = 16'd0;
                        posXNext    = X_CENTRE;
                        posYNext    = Y_CENTRE;
                        bulletXNext = X_MAX;
                        bulletYNext = Y_MIN;
                        hitCntNext  = 8'd0;
                    end
                end
                PLAY, HIT: begin
                    posXNext    = pxMoved;
                    posYNext    = pyMoved;
                    bulletXNext = bxMoved;
                    bulletYNext = byMoved;
                    if (collide) begin
                        bulletXNext = X_MAX;
                        bulletYNext = spawnY;
                        colorNext   = nextColor(color);
                        hpNext      = hpDec;
                        if (hpDec == 8'd0) begin
                            phaseNext = OVER;
                        end else begin
                            phaseNext  = HIT;
                            hitCntNext = HIT_FRAMES;
                        end
                    end else begin
                        if (respawn) begin
                            colorNext = nextColor(color);
                            scoreNext = (score == 16'hFFFF) ? score : (score + 16'd1);
                        end
                        if (phase == HIT) begin
                            if (hitCnt <= 8'd1) begin
                                hitCntNext = 8'd0;
                                phaseNext  = PLAY;
                            end else begin
                                hitCntNext = hitCnt - 8'd1;
                            end
                        end
                    end
                end
                OVER: begin
                    if (pending == CMD_START) begin
                        phaseNext   = IDLE;
                        hpNext      = HP_INIT;
                        scoreNext   = 16'd0;
                        posXNext    = X_CENTRE;
                        posYNext    = Y_CENTRE;
                        bulletXNext = X_MAX;
                        bulletYNext = Y_MIN;
                        colorNext   = 3'd1;
                        hitCntNext  = 8'd0;
                    end
                end
                default: ;
            endcase
        end

        isRenderNext = (phaseNext == PLAY) || (phaseNext == HIT);
    end

    // Game state register; reset wins over any frame update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= IDLE;
            hp        <= HP_INIT;
            score     <= 16'd0;
            posX      <= X_CENTRE;
            posY      <= Y_CENTRE;
            bulletX   <= X_MAX;
            bulletY   <= Y_MIN;
            color     <= 3'd1;
            hitCnt    <= 8'd0;
            pending   <= CMD_NONE;
            is_render <= 1'b0;
        end else begin
            phase     <= phaseNext;
            hp        <= hpNext;
            score     <= scoreNext;
            posX      <= posXNext;
            posY      <= posYNext;
            bulletX   <= bulletXNext;
            bulletY   <= bulletYNext;
            color     <= colorNext;
            hitCnt    <= hitCntNext;
            pending   <= pendingNext;
            is_render <= isRenderNext;
        end
    end

    // Pack the renderer-facing status word from the registered fields.
    always_comb begin
        state = '0;
        state[STATE_PHASE_LSB +: 2]  = phase;
        state[STATE_HP_LSB +: 8]     = hp;
        state[STATE_SCORE_LSB +: 16] = score;
    end

    assign player_pos   = packPos(posX, posY);
    assign bullet_pos   = packPos(bulletX, bulletY);
    assign bullet_color = color;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: table vectors, hand-written frame
// timing corners and randomized command streams against a behavioural model.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [15:0] player_pos;
    logic [15:0] bullet_pos;
    logic [2:0]  bullet_color;
    logic [31:0] state;
    logic        is_render;

    int vectors = 0;
    int miscompares = 0;

    int mPhase, mHp, mScore, mPx, mPy, mBx, mBy, mColor, mCnt, mPending, mLfsr;

    typedef struct {
        int cmdIn;
        int expPhase;
        int expX;
        int expY;
        int expBx;
    } vec_t;

    vec_t vecTable[7];

    game_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .player_pos   (player_pos),
        .bullet_pos   (bullet_pos),
        .bullet_color (bullet_color),
        .state        (state),
        .is_render    (is_render)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void modelGameReset();
        mPhase = 0; mHp = 5; mScore = 0;
        mPx = 80; mPy = 64; mBx = 144; mBy = 16;
        mColor = 1; mCnt = 0;
    endfunction

    function automatic void modelReset();
        modelGameReset();
        mPending = 0;
        mLfsr = 165;
    endfunction

    function automatic void modelUpdate();
        int c, spawnY;
        bit respawn, hit;
        c = mPending;
        mPending = 0;
`ifdef GAME_LFSR_SPAWN_EN
        spawnY = 16 + (mLfsr % 97);
`else
        spawnY = mPy;
`endif
        case (mPhase)
            0: if (c == 5) begin
                modelGameReset();
                mPhase = 1;
            end
            1, 2: begin
                if (c == 1) mPy = clampInt(mPy - 4, 16, 112);
                if (c == 2) mPy = clampInt(mPy + 4, 16, 112);
                if (c == 3) mPx = clampInt(mPx - 4, 16, 144);
                if (c == 4) mPx = clampInt(mPx + 4, 16, 144);
                respawn = (mBx < 20);
                if (respawn) begin
                    mBx = 144;
                    mBy = spawnY;
                end else begin
                    mBx = mBx - 4;
                end
                hit = (mPhase == 1) && (absInt(mPx - mBx) < 8) && (absInt(mPy - mBy) < 8);
                if (hit) begin
                    mBx = 144;
                    mBy = spawnY;
                    mColor = (mColor == 7) ? 1 : mColor + 1;
                    mHp = (mHp > 0) ? mHp - 1 : 0;
                    if (mHp == 0) mPhase = 3;
                    else begin
                        mPhase = 2;
                        mCnt = 16;
                    end
                end else begin
                    if (respawn) begin
                        mColor = (mColor == 7) ? 1 : mColor + 1;
                        if (mScore < 65535) mScore++;
                    end
                    if (mPhase == 2) begin
                        mCnt--;
                        if (mCnt <= 0) begin
                            mCnt = 0;
                            mPhase = 1;
                        end
                    end
                end
            end
            default: if (c == 5) modelGameReset();
        endcase
        mLfsr = ((mLfsr << 1) | (((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1)) & 255;
    endfunction

    function automatic logic [31:0] modelState();
        return 32'(mScore * 65536 + mHp * 4 + mPhase);
    endfunction

    function automatic logic [31:0] modelPlayer();
        return 32'(mPy * 256 + mPx);
    endfunction

    function automatic logic [31:0] modelBullet();
        return 32'(mBy * 256 + mBx);
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, " state"}, state, modelState());
        checkOutput({tag, " player_pos"}, 32'(player_pos), modelPlayer());
        checkOutput({tag, " bullet_pos"}, 32'(bullet_pos), modelBullet());
        checkOutput({tag, " bullet_color"}, 32'(bullet_color), 32'(mColor));
        checkOutput({tag, " is_render"}, 32'(is_render), 32'((mPhase == 1) || (mPhase == 2)));
    endtask

    task automatic applyReset();
        reset = 1'b1;
        vsync = 1'b1;
        cmd_valid = 1'b0;
        cmd = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
    endtask

    task automatic pulseCmd(input int c);
        @(posedge clk);
        #1 cmd_valid = 1'b1;
        cmd = 3'(c);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd = 3'd0;
        if (c != 0) mPending = c;
    endtask

    // One video frame: optional command, vsync falling edge, then settle.
    task automatic applyStimulus(input int c);
        if (c != 0) pulseCmd(c);
        @(posedge clk);
        #1 vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int frames;
        int c;

        vecTable[0] = '{1, 0, 80, 64, 144};
        vecTable[1] = '{5, 1, 80, 64, 144};
        vecTable[2] = '{1, 1, 80, 60, 140};
        vecTable[3] = '{4, 1, 84, 60, 136};
        vecTable[4] = '{2, 1, 84, 64, 132};
        vecTable[5] = '{3, 1, 80, 64, 128};
        vecTable[6] = '{0, 1, 80, 64, 124};

        applyReset();
        checkOutput("reset state", state, 32'h0000_0014);
        checkOutput("reset player_pos", 32'(player_pos), 32'h4050);
        checkOutput("reset bullet_pos", 32'(bullet_pos), 32'h1090);
        checkOutput("reset bullet_color", 32'(bullet_color), 32'd1);
        checkOutput("reset is_render", 32'(is_render), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecTable[i].cmdIn);
            checkOutput($sformatf("vec%0d phase", i), 32'(state[1:0]), 32'(vecTable[i].expPhase));
            checkOutput($sformatf("vec%0d player x", i), 32'(player_pos[7:0]), 32'(vecTable[i].expX));
            checkOutput($sformatf("vec%0d player y", i), 32'(player_pos[15:8]), 32'(vecTable[i].expY));
            checkOutput($sformatf("vec%0d bullet x", i), 32'(bullet_pos[7:0]), 32'(vecTable[i].expBx));
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus(3);
            if (i == 15) checkOutput("left clamp reached", 32'(player_pos), 32'h4010);
        end
        checkOutput("left clamp held", 32'(player_pos), 32'h4010);
        checkAll("left run");

        pulseCmd(4);
        @(posedge clk);
        #1 vsync = 1'b0;
        @(posedge clk);
        #1 checkOutput("latency edge1", 32'(player_pos), modelPlayer());
        @(posedge clk);
        #1 checkOutput("latency edge2", 32'(player_pos), modelPlayer());
        @(posedge clk);
        #1 modelUpdate();
        checkOutput("latency edge3", 32'(player_pos), 32'h4014);
        checkAll("latency");
        vsync = 1'b1;
        @(posedge clk);
        #1;

        pulseCmd(4);
        @(posedge clk);
        #1 vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        vsync = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset on update player", 32'(player_pos), 32'h4050);
        checkAll("reset on update");

        applyStimulus(5);
        @(posedge clk);
        #1 vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b1;
        cmd = 3'd4;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd = 3'd0;
        modelUpdate();
        mPending = 4;
        vsync = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cmd on update no move", 32'(player_pos), 32'h4050);
        applyStimulus(0);
        checkOutput("cmd on update applied", 32'(player_pos), 32'h4054);
        checkAll("cmd on update");

        applyReset();
        applyStimulus(5);
        for (int i = 0; i < 47; i++) applyStimulus(0);
        checkOutput("pre-hit state", state, 32'h0001_0015);
        checkOutput("pre-hit bullet_pos", 32'(bullet_pos), 32'h1058 + 32'h3000);
        applyStimulus(0);
        checkOutput("first hit state", state, 32'h0001_0012);
        checkOutput("first hit bullet_pos", 32'(bullet_pos), 32'h4090);
        checkOutput("first hit color", 32'(bullet_color), 32'd3);
        checkOutput("first hit is_render", 32'(is_render), 32'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0);
            checkOutput($sformatf("hit hold %0d", i), state, 32'h0001_0012);
        end
        applyStimulus(0);
        checkOutput("hit expiry state", state, 32'h0001_0011);
        checkOutput("hit expiry bullet_pos", 32'(bullet_pos), 32'h4050);

        frames = 0;
        while ((mPhase != 3) && (frames < 600)) begin
            applyStimulus(0);
            frames++;
        end
        checkOutput("reach over in budget", 32'(mPhase == 3), 32'd1);
        checkOutput("over phase and hp", state & 32'h0000_03FF, 32'h0000_0003);
        checkOutput("over is_render", 32'(is_render), 32'd0);
        checkAll("over");
        applyStimulus(4);
        checkAll("over frozen");
        applyStimulus(5);
        checkOutput("restart state", state, 32'h0000_0014);
        checkOutput("restart player_pos", 32'(player_pos), 32'h4050);
        checkOutput("restart bullet_pos", 32'(bullet_pos), 32'h1090);
        checkOutput("restart bullet_color", 32'(bullet_color), 32'd1);
        checkOutput("restart is_render", 32'(is_render), 32'd0);

        for (int i = 0; i < 300; i++) begin
            c = $urandom_range(0, 9);
            if (c > 5) c = (c == 9) ? 5 : 0;
            if ($urandom_range(0, 7) == 0) pulseCmd($urandom_range(1, 4));
            applyStimulus(c);
            checkAll($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
